// File: rtl/bus_pkg.sv
// Shared definitions for the bit-serial system bus master port.
// The SPLIT state exists only when MASTER_SPLIT_EN is defined.
package bus_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 12;
    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned BIT_CNT_W      = 4;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWdata,
        StRdata,
`ifdef MASTER_SPLIT_EN
        StSplit,
`endif
        StDone
    } master_state_t;

endpackage

// File: rtl/piso_shift.sv
// Parallel-load, shift-right-on-enable register; the LSB is the serial output.
module piso_shift #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             shift_i,
    output logic             lsb_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = {1'b0, sr_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign lsb_o = sr_q[0];

endmodule

// File: rtl/master_port.sv
// Bit-serial bus initiator: serialises address/write data, deserialises read data.
// Optional split support is compiled in with the MASTER_SPLIT_EN macro.
module master_port
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  read_en,
    output logic                  write_en,
    output logic                  master_valid,
    input  logic                  slave_ready,
    input  logic                  slave_valid,
    output logic                  master_ready,
    output logic                  tx_address,
    output logic                  tx_data,
    input  logic                  rx_data,
    input  logic                  split_en
);

    localparam int unsigned DATA_IDX_W = $clog2(DATA_WIDTH);
    localparam logic [BIT_CNT_W-1:0] ADDR_LAST = BIT_CNT_W'(ADDR_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_WIDTH - 1);

    master_state_t         state_q, state_d;
    logic [BIT_CNT_W-1:0]  cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

    logic accept;
    logic addr_shift;
    logic wdata_shift;
    logic addr_lsb;
    logic wdata_lsb;
    logic busy;

`ifndef MASTER_SPLIT_EN
    logic unused_split_en;
    assign unused_split_en = split_en;
`endif

    piso_shift #(
        .WIDTH (ADDR_WIDTH)
    ) u_addr_sr (
        .clk     (clk),
        .reset   (reset),
        .load_i  (accept),
        .data_i  (req_addr),
        .shift_i (addr_shift),
        .lsb_o   (addr_lsb)
    );

    piso_shift #(
        .WIDTH (DATA_WIDTH)
    ) u_wdata_sr (
        .clk     (clk),
        .reset   (reset),
        .load_i  (accept),
        .data_i  (req_wdata),
        .shift_i (wdata_shift),
        .lsb_o   (wdata_lsb)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        rdata_d      = rdata_q;
        resp_rdata_d = resp_rdata_q;
        accept       = 1'b0;
        addr_shift   = 1'b0;
        wdata_shift  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    write_d = req_write;
                    cnt_d   = '0;
                    rdata_d = '0;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (slave_ready) begin
                    addr_shift = 1'b1;
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d   = '0;
                        state_d = write_q ? StWdata : StRdata;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StWdata: begin
                if (slave_ready) begin
                    wdata_shift = 1'b1;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StRdata: begin
                // A bit arriving alongside a split request is captured first.
                if (slave_valid) begin
                    rdata_d[cnt_q[DATA_IDX_W-1:0]] = rx_data;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d        = '0;
                        resp_rdata_d = rdata_d;
                        state_d      = StDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef MASTER_SPLIT_EN
                else if (split_en) begin
                    state_d = StSplit;
                end
`endif
            end
`ifdef MASTER_SPLIT_EN
            StSplit: begin
                if (!split_en) begin
                    state_d = StRdata;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            rdata_q      <= '0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            rdata_q      <= rdata_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

`ifdef MASTER_SPLIT_EN
    assign busy = (state_q == StAddr) || (state_q == StWdata) ||
                  (state_q == StRdata) || (state_q == StSplit);
`else
    assign busy = (state_q == StAddr) || (state_q == StWdata) || (state_q == StRdata);
`endif

    // Every output decodes registered state only; no input reaches an output.
    assign req_ready    = (state_q == StIdle);
    assign master_valid = (state_q == StAddr) || (state_q == StWdata);
    assign master_ready = (state_q == StRdata);
    assign read_en      = busy && !write_q;
    assign write_en     = busy && write_q;
    assign tx_address   = (state_q == StAddr) && addr_lsb;
    assign tx_data      = (state_q == StWdata) && wdata_lsb;
    assign resp_valid   = (state_q == StDone);
    assign resp_rdata   = resp_rdata_q;

endmodule

// File: tb/tb_master_port.sv
// Directed, table-driven bench for master_port; split expectations follow MASTER_SPLIT_EN.
module tb_master_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [11:0] req_addr;
    logic [7:0]  req_wdata;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        read_en;
    logic        write_en;
    logic        master_valid;
    logic        slave_ready;
    logic        slave_valid;
    logic        master_ready;
    logic        tx_address;
    logic        tx_data;
    logic        rx_data;
    logic        split_en;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    master_port dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .read_en      (read_en),
        .write_en     (write_en),
        .master_valid (master_valid),
        .slave_ready  (slave_ready),
        .slave_valid  (slave_valid),
        .master_ready (master_ready),
        .tx_address   (tx_address),
        .tx_data      (tx_data),
        .rx_data      (rx_data),
        .split_en     (split_en)
    );

    typedef struct {
        logic       sready;
        logic       svalid;
        logic       rx;
        logic       tx_addr;
        logic       tx_dat;
        logic       mvalid;
        logic       mready;
        logic       wen;
        logic       ren;
        logic       resp;
        logic       rready;
        logic [7:0] rdata;
    } vec_t;

    vec_t vecs [1:22];

    // Bit sequences in transmission order (first bit at index 0).
    logic [0:11] addr3c1_seq = 12'b1000_0011_1100;
    logic [0:11] addr001_seq = 12'b1000_0000_0000;
    logic [0:7]  a5_seq      = 8'b1010_0101;
    logic [0:7]  x5a_seq     = 8'b0101_1010;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        slave_ready = 1'b0;
        slave_valid = 1'b0;
        rx_data     = 1'b0;
        split_en    = 1'b0;
    endtask

    // Presents a request in the idle cycle; returns in cycle 1.
    task automatic issue(input logic wr, input logic [11:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        chk("accept req_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag, input logic [7:0] rdata);
        chk({tag, " req_ready"}, req_ready, 1);
        chk({tag, " resp_valid"}, resp_valid, 0);
        chk({tag, " resp_rdata"}, resp_rdata, rdata);
        chk({tag, " read_en"}, read_en, 0);
        chk({tag, " write_en"}, write_en, 0);
        chk({tag, " master_valid"}, master_valid, 0);
        chk({tag, " master_ready"}, master_ready, 0);
        chk({tag, " tx_address"}, tx_address, 0);
        chk({tag, " tx_data"}, tx_data, 0);
    endtask

    task automatic fill_write(input logic [7:0] prior_rdata);
        for (int c = 1; c <= 22; c++) begin
            vecs[c] = '{sready: 1'b1, svalid: 1'b0, rx: 1'b0, tx_addr: 1'b0, tx_dat: 1'b0,
                        mvalid: 1'b0, mready: 1'b0, wen: 1'b0, ren: 1'b0, resp: 1'b0,
                        rready: 1'b0, rdata: prior_rdata};
            if (c <= 12) vecs[c].tx_addr = addr3c1_seq[c-1];
            if (c >= 13 && c <= 20) vecs[c].tx_dat = a5_seq[c-13];
            if (c <= 20) begin
                vecs[c].mvalid = 1'b1;
                vecs[c].wen    = 1'b1;
            end
            if (c == 21) vecs[c].resp = 1'b1;
            if (c == 22) vecs[c].rready = 1'b1;
        end
    endtask

    task automatic fill_read(input logic [7:0] prior_rdata);
        for (int c = 1; c <= 22; c++) begin
            vecs[c] = '{sready: 1'b1, svalid: 1'b0, rx: 1'b0, tx_addr: 1'b0, tx_dat: 1'b0,
                        mvalid: 1'b0, mready: 1'b0, wen: 1'b0, ren: 1'b0, resp: 1'b0,
                        rready: 1'b0, rdata: prior_rdata};
            if (c <= 12) begin
                vecs[c].tx_addr = addr001_seq[c-1];
                vecs[c].mvalid  = 1'b1;
            end
            if (c >= 13 && c <= 20) begin
                vecs[c].svalid = 1'b1;
                vecs[c].rx     = x5a_seq[c-13];
                vecs[c].mready = 1'b1;
            end
            if (c <= 20) vecs[c].ren = 1'b1;
            if (c == 21) vecs[c].resp = 1'b1;
            if (c >= 21) vecs[c].rdata = 8'h5A;
            if (c == 22) vecs[c].rready = 1'b1;
        end
    endtask

    task automatic run_vectors(input string tag);
        for (int c = 1; c <= 22; c++) begin
            slave_ready = vecs[c].sready;
            slave_valid = vecs[c].svalid;
            rx_data     = vecs[c].rx;
            chk($sformatf("%s c%0d tx_address", tag, c), tx_address, vecs[c].tx_addr);
            chk($sformatf("%s c%0d tx_data", tag, c), tx_data, vecs[c].tx_dat);
            chk($sformatf("%s c%0d master_valid", tag, c), master_valid, vecs[c].mvalid);
            chk($sformatf("%s c%0d master_ready", tag, c), master_ready, vecs[c].mready);
            chk($sformatf("%s c%0d write_en", tag, c), write_en, vecs[c].wen);
            chk($sformatf("%s c%0d read_en", tag, c), read_en, vecs[c].ren);
            chk($sformatf("%s c%0d resp_valid", tag, c), resp_valid, vecs[c].resp);
            chk($sformatf("%s c%0d req_ready", tag, c), req_ready, vecs[c].rready);
            chk($sformatf("%s c%0d resp_rdata", tag, c), resp_rdata, vecs[c].rdata);
            step();
        end
        idle_inputs();
    endtask

    initial begin
        int resp_cycle;
        int bit_idx;
        int resp_count;

        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check_idle_outputs("reset", 8'h00);

        issue(1'b1, 12'h3C1, 8'hA5);
        fill_write(8'h00);
        run_vectors("write");

        issue(1'b0, 12'h001, 8'hFF);
        fill_read(8'h00);
        run_vectors("read");

        // Address-phase stall: bit 6 (a 1) must be held through the stall.
        issue(1'b1, 12'h3C1, 8'hA5);
        resp_cycle = 0;
        for (int c = 1; c <= 30; c++) begin
            slave_ready = !(c >= 7 && c <= 9);
            if (c >= 7 && c <= 9) begin
                chk($sformatf("stall c%0d tx_address", c), tx_address, 1);
                chk($sformatf("stall c%0d master_valid", c), master_valid, 1);
            end
            if (resp_valid && resp_cycle == 0) resp_cycle = c;
            step();
        end
        idle_inputs();
        chk("stall resp cycle", resp_cycle, 24);

        // Reset sampled at edge 15 of a read aborts it.
        issue(1'b0, 12'h001, 8'h00);
        for (int c = 1; c <= 15; c++) begin
            slave_ready = 1'b1;
            slave_valid = (c >= 13);
            rx_data     = (c >= 13) ? x5a_seq[c-13] : 1'b0;
            reset       = (c == 15);
            step();
        end
        idle_inputs();
        reset = 1'b0;
        check_idle_outputs("abort c16", 8'h00);
        resp_count = 0;
        for (int c = 16; c <= 25; c++) begin
            if (resp_valid) resp_count++;
            step();
        end
        chk("abort no resp_valid", resp_count, 0);
        issue(1'b0, 12'h001, 8'h00);
        fill_read(8'h00);
        run_vectors("post-abort read");

        // Split window: split_en high, slave silent, in cycles 16..25.
        issue(1'b0, 12'h001, 8'h00);
        resp_cycle = 0;
        bit_idx    = 0;
        for (int c = 1; c <= 40; c++) begin
            slave_ready = 1'b1;
            split_en    = (c >= 16 && c <= 25);
            slave_valid = (c >= 13) && !split_en && (bit_idx < 8);
            rx_data     = (bit_idx < 8) ? x5a_seq[bit_idx] : 1'b0;
`ifdef MASTER_SPLIT_EN
            if (c == 20) chk("split master_ready", master_ready, 0);
            if (c == 20) chk("split read_en", read_en, 1);
`else
            if (c == 20) chk("split master_ready", master_ready, 1);
`endif
            if (resp_valid && resp_cycle == 0) begin
                resp_cycle = c;
                chk("split resp_rdata", resp_rdata, 8'h5A);
            end
            if (master_ready && slave_valid) bit_idx++;
            step();
        end
        idle_inputs();
`ifdef MASTER_SPLIT_EN
        chk("split resp cycle", resp_cycle, 32);
`else
        chk("split resp cycle", resp_cycle, 31);
`endif

        // req_valid held high: second request accepted only at edge 22.
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_addr    = 12'h3C1;
        req_wdata   = 8'hA5;
        slave_ready = 1'b1;
        chk("b2b accept req_ready", req_ready, 1);
        step();
        for (int c = 1; c <= 21; c++) begin
            chk($sformatf("b2b c%0d req_ready", c), req_ready, 0);
            if (c == 21) chk("b2b c21 resp_valid", resp_valid, 1);
            step();
        end
        chk("b2b c22 req_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        chk("b2b c23 master_valid", master_valid, 1);
        chk("b2b c23 req_ready", req_ready, 0);
        resp_cycle = 0;
        for (int c = 23; c <= 60; c++) begin
            if (resp_valid && resp_cycle == 0) resp_cycle = c;
            step();
        end
        idle_inputs();
        chk("b2b second resp cycle", resp_cycle, 43);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
